clog2_serial: RTL and testbench

Run-time counterpart of the elaboration-time `$clog2` system function. It accepts an unsigned operand over a valid/ready handshake and iteratively computes its ceiling base-2 logarithm with exactly `$clog2` semantics. It returns the result, the power-of-two round-up, and an exact-power flag over a second valid/ready handshake. It is the hardware reference the systest benches compare against `$clog2` constant folding, and it serves datapaths that size windows from run-time values.

---
 rtl/clog2_serial.sv | 60 ++++++
 tb/tb_clog2_serial.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clog2_serial.sv
// clog2_serial: iterative run-time $clog2 with power-of-two round-up and exact-power flag.
module clog2_serial #(
   parameter int WIDTH = 32,
   parameter int RW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RW-1:0]    out_log,
   output logic [WIDTH:0]   out_pow2,
   output logic             out_exact
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] v;
   logic [RW-1:0]    cnt;
   logic             exact;
   logic [WIDTH-1:0] xm1;
   logic             xz;
   assign xz        = in_data == '0;
   assign xm1       = xz ? '0 : in_data - WIDTH'(1);
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   // the bit length of x-1 equals the number of right shifts until it reaches zero
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         v         <= '0;
         cnt       <= '0;
         exact     <= 1'b0;
         out_log   <= '0;
         out_pow2  <= (WIDTH+1)'(1);
         out_exact <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               v     <= xm1;
               cnt   <= '0;
               exact <= !xz && ((in_data & xm1) == '0);
               state <= BUSY;
            end
            BUSY: if (v != '0) begin
               v   <= v >> 1;
               cnt <= cnt + RW'(1);
            end else begin
               out_log   <= cnt;
               out_pow2  <= (WIDTH+1)'(1) << cnt;
               out_exact <= exact;
               state     <= DONE;
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_clog2_serial.sv
// tb_clog2_serial: table, corner-sequence and random checks of clog2_serial against a ceil-log2 model.
module tb_clog2_serial;
   localparam int W  = 32;
   localparam int RW = 6;
   logic          clk = 0;
   logic          reset_n = 0;
   logic          in_valid = 0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 0;
   logic [RW-1:0] out_log;
   logic [W:0]    out_pow2;
   logic          out_exact;
   int tests = 0;
   int fails = 0;

   clog2_serial #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_log(out_log), .out_pow2(out_pow2), .out_exact(out_exact)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [W-1:0] x;
      int           lg;
      logic [W:0]   p2;
      logic         ex;
      int           lat;
   } vec_t;
   vec_t tbl[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // smallest r with 2**r >= x, straight from the definition
   function automatic int clog2_ref(input longint unsigned x);
      int r = 0;
      while ((64'd1 << r) < x) r++;
      return r;
   endfunction

   task automatic start_op(input logic [W-1:0] x, output int lat);
      int g = 0;
      in_valid = 1;
      in_data  = x;
      while (!in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      in_data  = W'($urandom);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         tests++;
         fails++;
         $display("FAIL timeout: no out_valid for x=%0h", x);
      end
   endtask

   task automatic take_result(output logic [RW-1:0] lg, output logic [W:0] p2, output logic ex);
      lg = out_log;
      p2 = out_pow2;
      ex = out_exact;
      out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 0;
   endtask

   initial begin
      int            lat;
      int            seen;
      int            r;
      logic [RW-1:0] lg;
      logic [W:0]    p2;
      logic          ex;
      logic [W-1:0]  x;
      tbl[0]  = '{32'd0,  0, 33'd1,  1'b0, 2};
      tbl[1]  = '{32'd1,  0, 33'd1,  1'b1, 2};
      tbl[2]  = '{32'd2,  1, 33'd2,  1'b1, 3};
      tbl[3]  = '{32'd3,  2, 33'd4,  1'b0, 4};
      tbl[4]  = '{32'd4,  2, 33'd4,  1'b1, 4};
      tbl[5]  = '{32'd5,  3, 33'd8,  1'b0, 5};
      tbl[6]  = '{32'd6,  3, 33'd8,  1'b0, 5};
      tbl[7]  = '{32'd7,  3, 33'd8,  1'b0, 5};
      tbl[8]  = '{32'd8,  3, 33'd8,  1'b1, 5};
      tbl[9]  = '{32'd9,  4, 33'd16, 1'b0, 6};
      tbl[10] = '{32'd10, 4, 33'd16, 1'b0, 6};
      tbl[11] = '{32'hFFFF_FFFF, 32, 33'h1_0000_0000, 1'b0, 34};
      tbl[12] = '{32'h8000_0000, 31, 33'h0_8000_0000, 1'b1, 33};

      reset_n  = 0;
      in_valid = 1;
      in_data  = 32'd7;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset out_log", 64'(out_log), 64'd0);
      chk("reset out_pow2", 64'(out_pow2), 64'd1);
      chk("reset out_exact", 64'(out_exact), 64'd0);
      reset_n  = 1;
      in_valid = 0;
      @(negedge clk);
      chk("post-reset in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 13; i++) begin
         start_op(tbl[i].x, lat);
         chk($sformatf("latency x=%0h", tbl[i].x), 64'(lat), 64'(tbl[i].lat));
         take_result(lg, p2, ex);
         chk($sformatf("log x=%0h", tbl[i].x), 64'(lg), 64'(tbl[i].lg));
         chk($sformatf("pow2 x=%0h", tbl[i].x), 64'(p2), 64'(tbl[i].p2));
         chk($sformatf("exact x=%0h", tbl[i].x), 64'(ex), 64'(tbl[i].ex));
         chk("in_ready after handshake", 64'(in_ready), 64'd1);
      end

      start_op(32'd5, lat);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_data  = 32'd2;
         @(negedge clk);
         chk("bp out_valid", 64'(out_valid), 64'd1);
         chk("bp in_ready", 64'(in_ready), 64'd0);
         chk("bp log", 64'(out_log), 64'd3);
         chk("bp pow2", 64'(out_pow2), 64'd8);
         chk("bp exact", 64'(out_exact), 64'd0);
      end
      in_valid  = 1;
      in_data   = 32'd2;
      out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 0;
      chk("bp drop out_valid", 64'(out_valid), 64'd0);
      chk("bp idle in_ready", 64'(in_ready), 64'd1);
      chk("bp held log", 64'(out_log), 64'd3);
      chk("bp held pow2", 64'(out_pow2), 64'd8);
      start_op(32'd2, lat);
      take_result(lg, p2, ex);
      chk("bp follow-on log", 64'(lg), 64'd1);
      chk("bp follow-on exact", 64'(ex), 64'd1);

      in_valid = 1;
      in_data  = 32'd1000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      repeat (2) @(negedge clk);
      reset_n = 0;
      @(negedge clk);
      reset_n = 1;
      chk("abort in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort no out_valid", 64'(seen), 64'd0);
      start_op(32'd3, lat);
      take_result(lg, p2, ex);
      chk("after abort log", 64'(lg), 64'd2);

      for (int i = 0; i < 40; i++) begin
         x = W'($urandom) >> $urandom_range(0, 31);
         r = clog2_ref(64'(x));
         start_op(x, lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         take_result(lg, p2, ex);
         chk($sformatf("rand lat x=%0h", x), 64'(lat), 64'(r + 2));
         chk($sformatf("rand log x=%0h", x), 64'(lg), 64'(r));
         chk($sformatf("rand pow2 x=%0h", x), 64'(p2), 64'd1 << r);
         chk($sformatf("rand exact x=%0h", x), 64'(ex), 64'(x != 0 && (64'd1 << r) == 64'(x)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
